// File: rtl/spdif_pkg.sv
// Shared S/PDIF framing constants, frame record and slot-to-bit mapping.
// Samples are stored MSB-aligned to 24 bits so slot 27 always carries the sample MSB.
package spdif_pkg;

  localparam int SLOTS_PER_SUBFRAME  = 32;
  localparam int AUDIO_SLOTS         = 24;
  localparam int HALFCELLS_PER_FRAME = 128;

  localparam logic [7:0] PRE_B = 8'b1110_1000;
  localparam logic [7:0] PRE_M = 8'b1110_0010;
  localparam logic [7:0] PRE_W = 8'b1110_0100;

  typedef struct packed {
    logic [AUDIO_SLOTS-1:0] left;
    logic [AUDIO_SLOTS-1:0] right;
    logic                   vbit;
    logic [1:0]             ubit;
    logic [1:0]             cbit;
  } spdif_frame_t;

  localparam spdif_frame_t IDLE_FRAME = '{left: '0, right: '0, vbit: 1'b1, ubit: 2'b00, cbit: 2'b00};

  // Data bit carried by slot 4..31 of subframe sub (0 = A, 1 = B); slot 31 is even parity.
  function automatic logic slot_bit(input spdif_frame_t f, input logic sub, input logic [4:0] slot);
    logic [AUDIO_SLOTS-1:0] smp;
    logic                   u;
    logic                   c;
    logic [4:0]             idx;
    smp = sub ? f.right : f.left;
    u   = f.ubit[sub];
    c   = f.cbit[sub];
    idx = slot - 5'd4;
    if (slot < 5'd28)      slot_bit = smp[idx];
    else if (slot == 5'd28) slot_bit = f.vbit;
    else if (slot == 5'd29) slot_bit = u;
    else if (slot == 5'd30) slot_bit = c;
    else                    slot_bit = ^{smp, f.vbit, u, c};
  endfunction

endpackage

// File: rtl/spdif_tick_gen.sv
// Half-cell strobe: tick is high for one cycle out of every CLK_DIV.
// Free running from reset; no backpressure.
module spdif_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic nreset,
  output logic tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div;

  assign tick = (div == DW'(CLK_DIV - 1));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset)   div <= '0;
    else if (tick) div <= '0;
    else           div <= div + DW'(1);
  end

endmodule

// File: rtl/spdif_frame_tx.sv
// IEC 60958 biphase-mark transmitter with a one-frame holding buffer; spdif_out registered, one change per tick.
// Frames are fetched on the tick starting half-cell 0; in_ready is low only while the buffer is full.
module spdif_frame_tx
  import spdif_pkg::*;
#(
  parameter int SAMPLE_WIDTH     = 24,
  parameter int CLK_DIV          = 4,
  parameter int FRAMES_PER_BLOCK = 192
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_WIDTH-1:0] in_left,
  input  logic [SAMPLE_WIDTH-1:0] in_right,
  input  logic                    in_vbit,
  input  logic [1:0]              in_ubit,
  input  logic [1:0]              in_cbit,
  output logic                    spdif_out,
  output logic                    block_start,
  output logic                    underrun
);

  localparam int HCW = $clog2(HALFCELLS_PER_FRAME);
  localparam int FW  = (FRAMES_PER_BLOCK > 1) ? $clog2(FRAMES_PER_BLOCK) : 1;

  logic           tick;
  logic           fetch;
  logic [HCW-1:0] hc;
  logic [FW-1:0]  frame_idx;
  logic           buf_full;
  logic           pre_inv;
  spdif_frame_t   buf_frame;
  spdif_frame_t   work;
  spdif_frame_t   in_frame;
  logic           sub;
  logic [5:0]     pos;
  logic [4:0]     slot;
  logic [7:0]     pre;
  logic           inv;
  logic           next_lvl;

  spdif_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clock  (clock),
    .nreset (nreset),
    .tick   (tick)
  );

  assign in_ready = ~buf_full;
  assign fetch    = tick && (hc == '0);

  always_comb begin
    in_frame       = '0;
    in_frame.left  = AUDIO_SLOTS'(in_left) << (AUDIO_SLOTS - SAMPLE_WIDTH);
    in_frame.right = AUDIO_SLOTS'(in_right) << (AUDIO_SLOTS - SAMPLE_WIDTH);
    in_frame.vbit  = in_vbit;
    in_frame.ubit  = in_ubit;
    in_frame.cbit  = in_cbit;
  end

  // Level for the half-cell that starts on the next tick; hc indexes that half-cell.
  always_comb begin
    sub  = hc[HCW-1];
    pos  = hc[5:0];
    slot = pos[5:1];
    if (sub)                  pre = PRE_W;
    else if (frame_idx == '0) pre = PRE_B;
    else                      pre = PRE_M;
    inv = (pos == '0) ? spdif_out : pre_inv;
    if (slot < 5'd4)  next_lvl = pre[3'd7 - pos[2:0]] ^ inv;
    else if (!pos[0]) next_lvl = ~spdif_out;
    else              next_lvl = spdif_out ^ slot_bit(work, sub, slot);
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      spdif_out   <= 1'b0;
      block_start <= 1'b0;
      underrun    <= 1'b0;
      hc          <= '0;
      frame_idx   <= '0;
      buf_full    <= 1'b0;
      buf_frame   <= '0;
      work        <= '0;
      pre_inv     <= 1'b0;
    end else begin
      block_start <= 1'b0;
      underrun    <= 1'b0;
      if (fetch) begin
        block_start <= (frame_idx == '0);
        if (buf_full) begin
          work     <= buf_frame;
          buf_full <= 1'b0;
        end else if (in_valid) begin
          work <= in_frame;
        end else begin
          work     <= IDLE_FRAME;
          underrun <= 1'b1;
        end
      end else if (in_valid && !buf_full) begin
        buf_frame <= in_frame;
        buf_full  <= 1'b1;
      end
      if (tick) begin
        spdif_out <= next_lvl;
        hc        <= hc + HCW'(1);
        if (pos == '0) pre_inv <= spdif_out;
        if (hc == HCW'(HALFCELLS_PER_FRAME - 1))
          frame_idx <= (frame_idx == FW'(FRAMES_PER_BLOCK - 1)) ? '0 : frame_idx + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_spdif_frame_tx.sv
// Directed and random frame streams into spdif_frame_tx (CLK_DIV=2); the line is sampled once per
// half-cell and compared frame by frame against an encoder model and hand-computed parity values.
module tb_spdif_frame_tx;
  import spdif_pkg::*;

  localparam int MAXHC = 30000;

  logic        clock    = 1'b0;
  logic        nreset   = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] in_left  = '0;
  logic [23:0] in_right = '0;
  logic        in_vbit  = 1'b0;
  logic [1:0]  in_ubit  = '0;
  logic [1:0]  in_cbit  = '0;
  logic        in_ready, spdif_out, block_start, underrun;

  logic        valid16  = 1'b1;
  logic [15:0] left16   = 16'h8000;
  logic [15:0] right16  = 16'h0000;
  logic        ready16, spdif16, bs16, ur16;

  always #5 clock = ~clock;

  spdif_frame_tx #(.SAMPLE_WIDTH(24), .CLK_DIV(2), .FRAMES_PER_BLOCK(192)) u_dut (
    .clock(clock), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .in_vbit(in_vbit), .in_ubit(in_ubit),
    .in_cbit(in_cbit), .spdif_out(spdif_out), .block_start(block_start), .underrun(underrun)
  );

  spdif_frame_tx #(.SAMPLE_WIDTH(16), .CLK_DIV(2), .FRAMES_PER_BLOCK(192)) u_dut16 (
    .clock(clock), .nreset(nreset), .in_valid(valid16), .in_ready(ready16),
    .in_left(left16), .in_right(right16), .in_vbit(1'b0), .in_ubit(2'b00),
    .in_cbit(2'b00), .spdif_out(spdif16), .block_start(bs16), .underrun(ur16)
  );

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic        v;
    logic [1:0]  u;
    logic [1:0]  c;
    logic        pa;
    logic        pb;
  } vec_t;

  vec_t         vt [6];
  int           checks = 0;
  int           errors = 0;
  bit           rec_lvl [MAXHC];
  bit           rec_ur  [MAXHC];
  bit           rec_bs  [MAXHC];
  bit           rec16   [MAXHC];
  int           hc_n   = 0;
  int           cyc    = 0;
  bit           synced = 1'b0;
  bit           phase  = 1'b0;
  int           bs_cyc [$];
  spdif_frame_t sched  [$];
  bit           exp_ur [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic spdif_frame_t mk(input logic [23:0] l, input logic [23:0] r, input logic v,
                                      input logic [1:0] u, input logic [1:0] c);
    spdif_frame_t f;
    f.left = l; f.right = r; f.vbit = v; f.ubit = u; f.cbit = c;
    return f;
  endfunction

  // Encoder model: preamble (inverted after a high level), then BMC slots 4..31 with even parity.
  function automatic logic [127:0] model_frame(input spdif_frame_t f, input bit is_b, input logic lvl0);
    logic [127:0] w;
    logic [7:0]   pre;
    logic [27:0]  d;
    logic         lvl;
    logic         inv;
    w   = '0;
    lvl = lvl0;
    for (int sb = 0; sb < 2; sb++) begin
      pre = (sb == 1) ? 8'b11100100 : (is_b ? 8'b11101000 : 8'b11100010);
      inv = lvl;
      for (int k = 0; k < 8; k++) w[sb*64 + k] = pre[7-k] ^ inv;
      lvl = w[sb*64 + 7];
      d[23:0] = (sb == 1) ? f.right : f.left;
      d[24]   = f.vbit;
      d[25]   = f.ubit[sb];
      d[26]   = f.cbit[sb];
      d[27]   = ^d[26:0];
      for (int s = 0; s < 28; s++) begin
        lvl = ~lvl;
        w[sb*64 + 8 + 2*s] = lvl;
        if (d[s]) lvl = ~lvl;
        w[sb*64 + 9 + 2*s] = lvl;
      end
    end
    return w;
  endfunction

  function automatic logic [127:0] rec_frame(input bit use16, input int base);
    logic [127:0] a;
    for (int k = 0; k < 128; k++) a[k] = use16 ? rec16[base + k] : rec_lvl[base + k];
    return a;
  endfunction

  function automatic logic [7:0] rec_byte(input int base);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7-k] = rec_lvl[base + k];
    return b;
  endfunction

  function automatic bit dec(input bit use16, input int base, input int s);
    if (use16) return rec16[base + 2*s] != rec16[base + 2*s + 1];
    return rec_lvl[base + 2*s] != rec_lvl[base + 2*s + 1];
  endfunction

  // Line-level checks: transition at every data slot boundary and even parity over slots 4..31.
  function automatic bit bmc_ok(input int base);
    bit ok;
    bit par;
    ok  = 1'b1;
    par = 1'b0;
    for (int s = 4; s < 32; s++) begin
      if (rec_lvl[base + 2*s] == rec_lvl[base + 2*s - 1]) ok = 1'b0;
      par ^= dec(1'b0, base, s);
    end
    return ok && !par;
  endfunction

  // Must be called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input spdif_frame_t f);
    int t;
    in_left = f.left; in_right = f.right; in_vbit = f.vbit; in_ubit = f.ubit; in_cbit = f.cbit;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 1000) begin @(negedge clock); t++; end
    if (!in_ready) fail_now("send_ready");
    @(negedge clock);
    in_valid = 1'b0;
    sched.push_back(f);
    exp_ur.push_back(1'b0);
  endtask

  // Half-cell sampler: first negedge of every half-cell, aligned on block_start.
  initial begin
    forever begin
      @(negedge clock);
      cyc++;
      if (!nreset) begin
        synced = 1'b0; hc_n = 0; phase = 1'b0;
      end else begin
        if (block_start) begin
          bs_cyc.push_back(cyc);
          if (!synced) begin synced = 1'b1; hc_n = 0; phase = 1'b0; end
        end
        if (synced) begin
          if (!phase && hc_n < MAXHC) begin
            rec_lvl[hc_n] = spdif_out;
            rec_ur[hc_n]  = underrun;
            rec_bs[hc_n]  = block_start;
            rec16[hc_n]   = spdif16;
            hc_n++;
          end
          phase = ~phase;
        end
      end
    end
  end

  initial begin
    int           t;
    int           n;
    logic         lvl;
    logic [127:0] w;
    logic [27:0]  d16;

    vt[0] = '{24'h000001, 24'h000000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
    vt[1] = '{24'hFFFFFF, 24'h000000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    vt[2] = '{24'h800000, 24'h000003, 1'b1, 2'b01, 2'b10, 1'b1, 1'b0};
    vt[3] = '{24'h123456, 24'hABCDEF, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0};
    vt[4] = '{24'h0F0F0F, 24'h000000, 1'b0, 2'b11, 2'b00, 1'b1, 1'b1};
    vt[5] = '{24'h000000, 24'h000000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};

    #12;
    chk("reset_state", 128'({spdif_out, in_ready, block_start, underrun}), 128'(4'b0100));
    chk("reset_state16", 128'({spdif16, ready16, bs16, ur16}), 128'(4'b0100));

    repeat (3) @(negedge clock);
    nreset = 1'b1;
    t = 0;
    while (!block_start && t < 20) begin @(negedge clock); t++; end
    if (!block_start) fail_now("first_block_start");
    chk("first_underrun", 128'(underrun), 128'(1'b1));
    sched.push_back(mk(24'h0, 24'h0, 1'b1, 2'b00, 2'b00));
    exp_ur.push_back(1'b1);

    // Buffered frame holds in_ready low until the next frame fetch, 255 negedges later.
    send(mk(vt[0].l, vt[0].r, vt[0].v, vt[0].u, vt[0].c));
    chk("ready_low_after_accept", 128'(in_ready), 128'(1'b0));
    n = 0;
    while (!in_ready && n < 400) begin @(negedge clock); n++; end
    chk("ready_rise_cycles", 128'(n), 128'(255));

    for (int i = 1; i < 6; i++) send(mk(vt[i].l, vt[i].r, vt[i].v, vt[i].u, vt[i].c));
    while (sched.size() < 100)
      send(mk(24'($urandom), 24'($urandom), 1'($urandom), 2'($urandom), 2'($urandom)));

    // Skip one fetch: the buffered frame drains, the following frame is an underrun.
    t = 0;
    while (!in_ready && t < 600) begin @(negedge clock); t++; end
    t = 0;
    while (!underrun && t < 600) begin @(negedge clock); t++; end
    if (!underrun) fail_now("drop_underrun");
    sched.push_back(mk(24'h0, 24'h0, 1'b1, 2'b00, 2'b00));
    exp_ur.push_back(1'b1);

    while (sched.size() < 196)
      send(mk(24'($urandom), 24'($urandom), 1'($urandom), 2'($urandom), 2'($urandom)));
    t = 0;
    while (hc_n < sched.size() * 128 && t < 60000) begin @(negedge clock); t++; end
    if (hc_n < sched.size() * 128) fail_now("record_frames");

    lvl = 1'b0;
    for (int f = 0; f < sched.size(); f++) begin
      w = model_frame(sched[f], (f % 192) == 0, lvl);
      lvl = w[127];
      chk($sformatf("frame%0d_wave", f), rec_frame(1'b0, f*128), w);
      chk($sformatf("frame%0d_underrun", f), 128'(rec_ur[f*128]), 128'(exp_ur[f]));
      chk($sformatf("frame%0d_block_start", f), 128'(rec_bs[f*128]), 128'((f % 192) == 0));
    end

    for (int i = 0; i < 6; i++) begin
      chk($sformatf("vec%0d_parity_a", i), 128'(dec(1'b0, (i+1)*128, 31)), 128'(vt[i].pa));
      chk($sformatf("vec%0d_parity_b", i), 128'(dec(1'b0, (i+1)*128 + 64, 31)), 128'(vt[i].pb));
    end
    chk("frame0_preamble_b", 128'(rec_byte(0)), 128'(8'hE8));
    chk("frame0_vbit", 128'(dec(1'b0, 0, 28)), 128'(1'b1));
    chk("frame1_slot4_mid", 128'(dec(1'b0, 128, 4)), 128'(1'b1));
    chk("frame1_preamble_m", 128'(rec_byte(128)), 128'(8'hE2));
    chk("frame1_preamble_w", 128'(rec_byte(128 + 64)), 128'(8'hE4));
    chk("frame192_preamble_b", 128'(rec_byte(192*128)), 128'(8'hE8));
    chk("drop_frame_vbit", 128'(dec(1'b0, 100*128, 28)), 128'(1'b1));
    for (int f = 7; f < 17; f++) begin
      chk($sformatf("frame%0d_bmc_a", f), 128'(bmc_ok(f*128)), 128'(1'b1));
      chk($sformatf("frame%0d_bmc_b", f), 128'(bmc_ok(f*128 + 64)), 128'(1'b1));
    end
    if (bs_cyc.size() < 2) fail_now("block_period");
    else chk("block_period", 128'(bs_cyc[1] - bs_cyc[0]), 128'(192*128*2));

    for (int s = 4; s < 32; s++) d16[s-4] = dec(1'b1, 0, s);
    chk("w16_slots", 128'(d16), 128'(28'h8800000));
    chk("w16_wave", rec_frame(1'b1, 0), model_frame(mk(24'h800000, 24'h0, 1'b0, 2'b00, 2'b00), 1'b1, 1'b0));

    // Reset mid-frame with a full buffer: outputs clear at once, next frame restarts the block.
    in_left = 24'h5A5A5A; in_valid = 1'b1;
    t = 0;
    while (in_ready && t < 600) begin @(negedge clock); t++; end
    in_valid = 1'b0;
    t = 0;
    while (!spdif_out && t < 50) begin @(negedge clock); t++; end
    if (!spdif_out) fail_now("midreset_high");
    #2 nreset = 1'b0;
    #1 chk("midreset_state", 128'({spdif_out, in_ready, block_start, underrun}), 128'(4'b0100));
    repeat (3) @(negedge clock);
    nreset = 1'b1;
    t = 0;
    while (!block_start && t < 20) begin @(negedge clock); t++; end
    if (!block_start) fail_now("restart_block_start");
    repeat (260) @(negedge clock);
    chk("restart_underrun", 128'(rec_ur[0]), 128'(1'b1));
    chk("restart_wave", rec_frame(1'b0, 0), model_frame(mk(24'h0, 24'h0, 1'b1, 2'b00, 2'b00), 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
